// File: rtl/gcd_host_driver.sv
// Feeds two operands to a subtractive GCD processor (Input/Enter handshake), waits for Halt, returns the GCD.
// Latency: 2*(SETUP_CYCLES+PULSE_CYCLES) cycles from Start to WAIT_HALT, then up to TIMEOUT_CYCLES, plus one FINISH cycle.
// Backpressure: none; Start is only sampled in IDLE and is ignored while Busy.
module gcd_host_driver #(
    parameter int SETUP_CYCLES   = 5,
    parameter int PULSE_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [7:0] OperandA,
    input  logic [7:0] OperandB,
    output logic       Busy,
    output logic       Done,
    output logic       Error,
    output logic       Timeout,
    output logic [7:0] Result,
    output logic [7:0] ProcInput,
    output logic       ProcEnter,
    input  logic       ProcHalt,
    input  logic [7:0] ProcOutput
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP_A,
        ENTER_A,
        SETUP_B,
        ENTER_B,
        WAIT_HALT,
        FINISH
    } state_t;

    localparam logic [15:0] SETUP_LAST   = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] PULSE_LAST   = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  b_q, b_d;
    logic        halt_q;
    logic        halt_edge;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        timeout_q, timeout_d;
    logic [7:0]  result_q, result_d;
    logic [7:0]  proc_input_q, proc_input_d;
    logic        proc_enter_q, proc_enter_d;

    // halt_q is the previous-cycle Halt, so a level already high on entry to WAIT_HALT is not an edge.
    assign halt_edge = ProcHalt & ~halt_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        b_d          = b_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        timeout_d    = timeout_q;
        result_d     = result_q;
        proc_input_d = proc_input_q;
        proc_enter_d = proc_enter_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    // A zero operand would make the subtractive GCD spin forever.
                    if ((OperandA != 8'h00) && (OperandB != 8'h00)) begin
                        state_d      = SETUP_A;
                        cnt_d        = 16'd0;
                        b_d          = OperandB;
                        proc_input_d = OperandA;
                        proc_enter_d = 1'b0;
                        timeout_d    = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            SETUP_A: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d      = ENTER_A;
                    cnt_d        = 16'd0;
                    proc_enter_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ENTER_A: begin
                if (cnt_q == PULSE_LAST) begin
                    // Input only moves on the same edge that drops Enter.
                    state_d      = SETUP_B;
                    cnt_d        = 16'd0;
                    proc_enter_d = 1'b0;
                    proc_input_d = b_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SETUP_B: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d      = ENTER_B;
                    cnt_d        = 16'd0;
                    proc_enter_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ENTER_B: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d      = WAIT_HALT;
                    cnt_d        = 16'd0;
                    proc_enter_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            WAIT_HALT: begin
                // Halt edge is checked first so it wins over a coincident timeout.
                if (halt_edge) begin
                    state_d  = FINISH;
                    cnt_d    = 16'd0;
                    result_d = ProcOutput;
                    done_d   = 1'b1;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = FINISH;
                    cnt_d     = 16'd0;
                    timeout_d = 1'b1;
                    error_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
            default: begin
                state_d      = IDLE;
                cnt_d        = 16'd0;
                proc_enter_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= 16'd0;
            b_q          <= 8'h00;
            halt_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            result_q     <= 8'h00;
            proc_input_q <= 8'h00;
            proc_enter_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            b_q          <= b_d;
            halt_q       <= ProcHalt;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            timeout_q    <= timeout_d;
            result_q     <= result_d;
            proc_input_q <= proc_input_d;
            proc_enter_q <= proc_enter_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Error     = error_q;
    assign Timeout   = timeout_q;
    assign Result    = result_q;
    assign ProcInput = proc_input_q;
    assign ProcEnter = proc_enter_q;

endmodule

// File: tb/tb_gcd_host_driver.sv
// Directed bench for gcd_host_driver with a behavioural GCD processor model.
module tb_gcd_host_driver;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] OperandA = 8'h00;
    logic [7:0] OperandB = 8'h00;
    logic       Busy, Done, Error, Timeout, ProcEnter;
    logic [7:0] Result, ProcInput;
    logic       ProcHalt = 1'b0;
    logic [7:0] ProcOutput = 8'h00;

    gcd_host_driver dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .OperandA   (OperandA),
        .OperandB   (OperandB),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error),
        .Timeout    (Timeout),
        .Result     (Result),
        .ProcInput  (ProcInput),
        .ProcEnter  (ProcEnter),
        .ProcHalt   (ProcHalt),
        .ProcOutput (ProcOutput)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gcd8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] y;
        x = a;
        y = b;
        if (x == 8'h00 || y == 8'h00) return 8'h00;
        while (x != y) begin
            if (x > y) x = x - y;
            else       y = y - x;
        end
        return x;
    endfunction

    // Processor model and monitor. mode 0: halt 6 cycles after operand B,
    // mode 1: never halts, mode 2: halt high before entry, then low, then high.
    int         mode = 0;
    int         phase = 0;
    int         hold = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         error_cnt = 0;
    int         enter_rises = 0;
    int         glitches = 0;
    int         n_rise = 0;
    int         n_fall = 0;
    int         busy_rise_cyc = 0;
    int         wait_entry_cyc = 0;
    int         err_cyc = 0;
    int         done_before_rise = 0;
    int         rise_cyc [2];
    int         fall_cyc [2];
    logic [7:0] cap [2];
    logic [7:0] in_at_rise = 8'h00;
    logic       enter_prev = 1'b0;
    logic       busy_prev = 1'b0;

    always begin
        @(posedge Clock);
        #1;
        cyc++;
        if (Reset) begin
            phase      = 0;
            n_rise     = 0;
            n_fall     = 0;
            enter_prev = 1'b0;
            busy_prev  = 1'b0;
            ProcHalt   = 1'b0;
        end else begin
            if (Done) done_cnt++;
            if (Error) begin
                error_cnt++;
                err_cyc = cyc;
            end
            if (Busy && !busy_prev) begin
                busy_rise_cyc = cyc;
                n_rise = 0;
                n_fall = 0;
            end
            if (ProcEnter && !enter_prev) begin
                enter_rises++;
                if (n_rise < 2) begin
                    rise_cyc[n_rise] = cyc;
                    cap[n_rise] = ProcInput;
                end
                n_rise++;
                in_at_rise = ProcInput;
                if (mode != 2) ProcHalt = 1'b0;
            end
            if (ProcEnter && ProcInput != in_at_rise) glitches++;
            if (!ProcEnter && enter_prev) begin
                if (n_fall < 2) fall_cyc[n_fall] = cyc;
                n_fall++;
                if (n_fall == 2) begin
                    wait_entry_cyc = cyc;
                    phase = (mode == 1) ? 0 : 1;
                    hold  = (mode == 2) ? 10 : 6;
                end
            end
            if (phase == 1) begin
                if (hold > 0) hold--;
                else if (mode == 2) begin
                    ProcHalt = 1'b0;
                    hold = 5;
                    phase = 2;
                end else begin
                    ProcOutput = gcd8(cap[0], cap[1]);
                    ProcHalt = 1'b1;
                    phase = 0;
                end
            end else if (phase == 2) begin
                if (hold > 0) hold--;
                else begin
                    ProcOutput = gcd8(cap[0], cap[1]);
                    ProcHalt = 1'b1;
                    done_before_rise = done_cnt;
                    phase = 0;
                end
            end
            if (mode == 2 && !Busy) begin
                ProcHalt = 1'b1;
                ProcOutput = 8'hEE;
            end
            if (mode == 1) ProcHalt = 1'b0;
            enter_prev = ProcEnter;
            busy_prev  = Busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic start_txn(input logic [7:0] a, input logic [7:0] b);
        @(negedge Clock);
        OperandA = a;
        OperandB = b;
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (!(Done || Error) && k < 3000) begin
            @(negedge Clock);
            k++;
        end
        check({tag, "_end_reached"}, (Done || Error), 1'b1);
    endtask

    task automatic wait_enter(input string tag);
        int k = 0;
        while (!ProcEnter && k < 200) begin
            @(negedge Clock);
            k++;
        end
        check({tag, "_enter_seen"}, ProcEnter, 1'b1);
    endtask

    int d0;
    int e0;
    int r0;

    initial begin
        tick(2);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_error", Error, 0);
        check("rst_timeout", Timeout, 0);
        check("rst_result", Result, 0);
        check("rst_procinput", ProcInput, 0);
        check("rst_procenter", ProcEnter, 0);
        Reset = 1'b0;
        tick(2);

        // Normal transaction 36/24 -> 12
        mode = 0;
        d0 = done_cnt;
        e0 = error_cnt;
        start_txn(8'd36, 8'd24);
        wait_end("t38");
        check("t38_done", Done, 1);
        check("t38_result", Result, 12);
        check("t38_busy_finish", Busy, 1);
        check("t38_cap_a", cap[0], 36);
        check("t38_cap_b", cap[1], 24);
        check("t38_setup_a_len", rise_cyc[0] - busy_rise_cyc, 5);
        check("t38_pulse_a_len", fall_cyc[0] - rise_cyc[0], 5);
        check("t38_setup_b_len", rise_cyc[1] - fall_cyc[0], 5);
        check("t38_pulse_b_len", fall_cyc[1] - rise_cyc[1], 5);
        check("t38_latency", wait_entry_cyc - busy_rise_cyc, 20);
        check("t38_input_stable", glitches, 0);
        tick(2);
        check("t38_busy_idle", Busy, 0);
        check("t38_done_pulses", done_cnt - d0, 1);
        check("t38_error_pulses", error_cnt - e0, 0);

        // Zero operand rejected
        r0 = enter_rises;
        start_txn(8'd0, 8'd7);
        check("t39_error", Error, 1);
        check("t39_busy", Busy, 0);
        tick(1);
        check("t39_error_one_cycle", Error, 0);
        tick(4);
        check("t39_busy_after", Busy, 0);
        check("t39_result_kept", Result, 12);
        check("t39_no_enter", enter_rises - r0, 0);

        // Timeout with Halt tied low
        mode = 1;
        tick(1);
        e0 = error_cnt;
        d0 = done_cnt;
        start_txn(8'd5, 8'd5);
        wait_end("t40");
        check("t40_error", Error, 1);
        check("t40_timeout", Timeout, 1);
        check("t40_timeout_delay", err_cyc - wait_entry_cyc, 1023);
        check("t40_result_kept", Result, 12);
        tick(2);
        check("t40_busy_low", Busy, 0);
        check("t40_timeout_sticky", Timeout, 1);
        check("t40_error_pulses", error_cnt - e0, 1);
        check("t40_no_done", done_cnt - d0, 0);

        // Halt already high on entry to WAIT_HALT
        mode = 2;
        tick(2);
        d0 = done_cnt;
        start_txn(8'd9, 8'd6);
        check("t41_timeout_cleared", Timeout, 0);
        wait_end("t41");
        check("t41_done", Done, 1);
        check("t41_result", Result, 3);
        check("t41_no_early_done", done_before_rise - d0, 0);
        tick(2);

        // Start re-pulsed during ENTER_A is ignored
        mode = 0;
        tick(2);
        d0 = done_cnt;
        start_txn(8'd12, 8'd18);
        wait_enter("t42");
        OperandA = 8'd9;
        Start = 1'b1;
        tick(3);
        Start = 1'b0;
        wait_end("t42");
        check("t42_result", Result, 6);
        check("t42_cap_a", cap[0], 12);
        tick(3);
        check("t42_done_pulses", done_cnt - d0, 1);
        check("t42_busy_idle", Busy, 0);

        // Start held high restarts on the first IDLE cycle
        @(negedge Clock);
        OperandA = 8'd8;
        OperandB = 8'd12;
        Start = 1'b1;
        wait_end("held1");
        check("held1_result", Result, 4);
        tick(1);
        check("held_idle_gap", Busy, 0);
        tick(1);
        check("held_restart", Busy, 1);
        Start = 1'b0;
        wait_end("held2");
        check("held2_done", Done, 1);
        tick(2);

        // Reset mid-Enter pulse drops ProcEnter asynchronously
        start_txn(8'd20, 8'd30);
        wait_enter("rst_mid");
        #2 Reset = 1'b1;
        #1;
        check("rst_mid_enter", ProcEnter, 0);
        check("rst_mid_busy", Busy, 0);
        check("rst_mid_input", ProcInput, 0);
        check("rst_mid_result", Result, 0);
        @(negedge Clock);
        Reset = 1'b0;
        tick(2);

        // Reset in WAIT_HALT, then a normal 14/21 transaction
        mode = 1;
        tick(1);
        start_txn(8'd5, 8'd5);
        tick(30);
        check("t43_in_wait", Busy, 1);
        #2 Reset = 1'b1;
        #1;
        check("t43_busy", Busy, 0);
        check("t43_done", Done, 0);
        check("t43_error", Error, 0);
        check("t43_timeout", Timeout, 0);
        check("t43_result", Result, 0);
        check("t43_input", ProcInput, 0);
        check("t43_enter", ProcEnter, 0);
        @(negedge Clock);
        Reset = 1'b0;
        mode = 0;
        tick(2);
        start_txn(8'd14, 8'd21);
        wait_end("t43b");
        check("t43b_done", Done, 1);
        check("t43b_result", Result, 7);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
